// File: rtl/adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM state encoding and
// helpers that size the slice counter from the operand geometry.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A one-slice configuration still needs a one-bit index register.
    function automatic int calc_idx_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit adder with carry in/out; the top reuses one
// instance every cycle on whichever slice the index selects.
module chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/multicycle_adder.sv
// Chunk-serial add/subtract: operands are latched on acceptance and summed
// CHUNK bits per cycle, with the result held until the consumer takes it.
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             busy
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDXW   = calc_idx_width(NCHUNK);

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic              sub_reg;
    logic              carry_reg;
    logic [IDXW-1:0]   idx_reg;
    logic [WIDTH:0]    sum_reg, sum_next;

    logic [CHUNK-1:0]  a_slice [NCHUNK];
    logic [CHUNK-1:0]  b_slice [NCHUNK];
    logic [CHUNK-1:0]  a_sel, b_sel, s_chunk;
    logic              c_chunk;
    logic              is_last;

    assign is_last = (idx_reg == IDXW'(NCHUNK - 1));

    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
        assign a_slice[gi] = a_reg[gi*CHUNK +: CHUNK];
        assign b_slice[gi] = b_reg[gi*CHUNK +: CHUNK];
        assign sum_next[gi*CHUNK +: CHUNK] =
            (state_reg == CALC && idx_reg == IDXW'(gi)) ? s_chunk : sum_reg[gi*CHUNK +: CHUNK];
    end

    // Carry-out of the final slice becomes the top bit; for subtraction it
    // is inverted so the top bit reads as a borrow.
    assign sum_next[WIDTH] = (state_reg == CALC && is_last) ? (c_chunk ^ sub_reg) : sum_reg[WIDTH];

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_reg == IDXW'(i)) begin
                a_sel = a_slice[i];
                b_sel = b_slice[i];
            end
        end
    end

    chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .a    (a_sel),
        .b    (b_sel),
        .cin  (carry_reg),
        .s    (s_chunk),
        .cout (c_chunk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (in_valid)  state_next = CALC;
            CALC:    if (is_last)   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
        busy      = (state_reg != IDLE);
    end

    // Subtraction is done as A + ~B + 1, so the inverted operand and a
    // carry-in of one are captured at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            sum_reg   <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        sub_reg   <= sub;
                        carry_reg <= sub;
                        idx_reg   <= '0;
                    end
                end
                CALC: begin
                    carry_reg <= c_chunk;
                    idx_reg   <= is_last ? '0 : idx_reg + 1'b1;
                    sum_reg   <= sum_next;
                end
                default: begin
                end
            endcase
        end
    end

    assign sum = sum_reg;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: three geometries (16/4, 8/8, 32/4) driven with
// directed and random operations, checked against plain-arithmetic results.
module tb_multicycle_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  in_valid_v  = '0;
    logic [2:0]  sub_v       = '0;
    logic [2:0]  out_ready_v = '0;
    logic [2:0]  in_ready_v, out_valid_v, busy_v;
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    logic [16:0] sum16;
    logic [8:0]  sum8;
    logic [32:0] sum32;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut_16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0][15:0]), .b(b_v[0][15:0]), .sub(sub_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .sum(sum16), .busy(busy_v[0])
    );

    multicycle_adder #(.WIDTH(8), .CHUNK(8)) dut_8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .sub(sub_v[1]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .sum(sum8), .busy(busy_v[1])
    );

    multicycle_adder #(.WIDTH(32), .CHUNK(4)) dut_32 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .sub(sub_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .sum(sum32), .busy(busy_v[2])
    );

    function automatic int width_of(input int k);
        return (k == 0) ? 16 : (k == 1) ? 8 : 32;
    endfunction

    function automatic int nchunk_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : 8;
    endfunction

    function automatic logic [63:0] get_sum(input int k);
        return (k == 0) ? 64'(sum16) : (k == 1) ? 64'(sum8) : 64'(sum32);
    endfunction

    // Result bit WIDTH is the carry of a+b, or the borrow (a<b) of a-b.
    function automatic logic [63:0] ref_result(input int w, input logic [63:0] a,
                                               input logic [63:0] b, input logic s);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        if (!s) return a + b;
        return ((a - b) & mask) | ((a < b) ? (64'd1 << w) : 64'd0);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Latency counts edges from the accepting edge (inclusive) to the first
    // edge after which out_valid is high.
    task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input int hold);
        logic [63:0] exp, held;
        int lat;
        exp = ref_result(width_of(k), a, b, s);
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready_v[k]), 64'd1);
        a_v[k] = a[31:0];
        b_v[k] = b[31:0];
        sub_v[k] = s;
        in_valid_v[k] = 1'b1;
        out_ready_v[k] = (hold == 0);
        @(posedge clk);
        #1;
        in_valid_v[k] = 1'b0;
        a_v[k] = $urandom;
        b_v[k] = $urandom;
        sub_v[k] = ~s;
        lat = 1;
        while (!out_valid_v[k] && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(nchunk_of(k) + 1));
        check("sum", get_sum(k), exp);
        $display("op cfg=%0d a=%h b=%h sub=%0d sum=%h exp=%h lat=%0d hold=%0d",
                 k, a, b, s, get_sum(k), exp, lat, hold);
        held = get_sum(k);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(out_valid_v[k]), 64'd1);
            check("hold_sum", get_sum(k), held);
            check("hold_in_ready", 64'(in_ready_v[k]), 64'd0);
        end
        out_ready_v[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[k] = 1'b0;
        check("back_to_idle", 64'(in_ready_v[k]), 64'd1);
        check("valid_dropped", 64'(out_valid_v[k]), 64'd0);
    endtask

    initial begin
        logic [63:0] ra, rb, mask;
        int w;
        for (int k = 0; k < 3; k++) begin
            a_v[k] = '0;
            b_v[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_in_ready", 64'(in_ready_v[k]), 64'd1);
            check("rst_out_valid", 64'(out_valid_v[k]), 64'd0);
            check("rst_busy", 64'(busy_v[k]), 64'd0);
            check("rst_sum", get_sum(k), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        run_op(0, 64'h0045, 64'h0012, 1'b0, 0);
        check("dir_add", get_sum(0), 64'h00057);
        run_op(0, 64'h0012, 64'h0045, 1'b1, 0);
        check("dir_sub_borrow", get_sum(0), 64'h1FFCD);
        run_op(0, 64'h0045, 64'h0012, 1'b1, 0);
        check("dir_sub", get_sum(0), 64'h00033);
        run_op(0, 64'hFFFF, 64'h0001, 1'b0, 0);
        check("dir_carry_chain", get_sum(0), 64'h10000);
        run_op(0, 64'hABCD, 64'h1234, 1'b1, 10);

        // Reset in the middle of CALC while slice 2 is being processed
        @(negedge clk);
        a_v[0] = 32'h1234;
        b_v[0] = 32'h4321;
        sub_v[0] = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midcalc_busy", 64'(busy_v[0]), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(out_valid_v[0]), 64'd0);
        check("midrst_sum", get_sum(0), 64'd0);
        check("midrst_busy", 64'(busy_v[0]), 64'd0);
        check("midrst_in_ready", 64'(in_ready_v[0]), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_valid", 64'(out_valid_v[0]), 64'd0);
        end
        run_op(0, 64'd1, 64'd2, 1'b0, 0);
        check("post_rst_op", get_sum(0), 64'd3);

        run_op(1, 64'hFF, 64'hFF, 1'b0, 0);
        run_op(1, 64'h00, 64'hFF, 1'b1, 2);
        run_op(2, 64'hFFFF_FFFF, 64'd1, 1'b0, 0);
        run_op(2, 64'd0, 64'd1, 1'b1, 3);

        for (int k = 0; k < 3; k++) begin
            w = width_of(k);
            mask = (64'd1 << w) - 64'd1;
            for (int n = 0; n < ((k == 0) ? 200 : 1000); n++) begin
                ra = 64'($urandom) & mask;
                rb = 64'($urandom) & mask;
                run_op(k, ra, rb, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits added per cycle; WIDTH % CHUNK == 0 SHALL hold; NCHUNK = WIDTH/CHUNK.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 The block SHALL have the following ports:
  clk  input  1  clock, all state on rising edge
  rst  input  1  asynchronous active-high reset
  in_valid  input  1  operand request valid
  in_ready  output  1  block can accept operands
  a  input  WIDTH  operand A
  b  input  WIDTH  operand B
  sub  input  1  0 = A+B, 1 = A-B
  out_valid  output  1  result valid
  out_ready  input  1  consumer accepts result
  sum  output  WIDTH+1  result; sum[WIDTH] = carry (add) or borrow (sub)
  busy  output  1  high in CALC or DONE

Function
REQ-005 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-006 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-007 An input handshake (in_valid & in_ready at a rising edge) SHALL latch a, sub, and b_eff = sub ? ~b : b, set carry = sub and chunk index = 0, and move to CALC.
REQ-008 In CALC, each cycle SHALL compute {c, s} = a[idx] + b_eff[idx] + carry over one CHUNK-bit slice, write s into sum slice idx, set carry = c, and increment idx.
REQ-009 After the slice with idx == NCHUNK-1, the FSM SHALL go to DONE and set sum[WIDTH] = carry for add, or ~carry (borrow) for sub.
REQ-010 out_valid SHALL be 1 only in DONE; it SHALL first assert NCHUNK+1 cycles after the input-handshake edge (5 cycles for the defaults).
REQ-011 While out_valid=1 and out_ready=0, sum and out_valid SHALL hold stable.
REQ-012 An output handshake (out_valid & out_ready) SHALL return the FSM to IDLE on the next edge; out_ready asserted in advance SHALL complete the handshake in the first DONE cycle.
REQ-013 Changes to a, b, sub or in_valid after acceptance SHALL NOT affect the operation in flight.
REQ-014 The arithmetic SHALL be modulo 2^WIDTH in sum[WIDTH-1:0]; no saturation.
REQ-015 With NCHUNK == 1, CALC SHALL last exactly one cycle.
REQ-016 The minimum spacing between accepted operations SHALL be NCHUNK+2 cycles.

Reset
REQ-017 While rst=1, the state SHALL be IDLE, sum = 0, out_valid = 0, busy = 0, carry = 0, idx = 0, and in_ready = 1.
REQ-018 Reset asserted mid-operation SHALL discard the operation with no result delivered; the first edge after reset release SHALL be able to accept a new input.

Structure
REQ-019 The shared package adder_pkg SHALL hold the state enum (IDLE/CALC/DONE) and the function computing NCHUNK and the index width, clog2(NCHUNK), minimum 1.
REQ-020 One sub-module, chunk_add, SHALL exist: a combinational CHUNK-bit adder with carry-in and carry-out, instantiated once and reused each cycle via a slice mux.

Verification
REQ-021 Add, defaults: a=16'h0045, b=16'h0012, sub=0, out_ready=1 -> out_valid after 5 cycles, sum=17'h00057 (87).
REQ-022 Sub with borrow: a=16'h0012, b=16'h0045, sub=1 -> sum=17'h1FFCD; sub with a=16'h0045, b=16'h0012 -> sum=17'h00033.
REQ-023 Carry across all slices: a=16'hFFFF, b=16'h0001, sub=0 -> sum=17'h10000.
REQ-024 Back-pressure: hold out_ready=0 for 10 cycles -> sum and out_valid stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-025 Reset mid-CALC: assert rst at chunk 2 -> out_valid stays 0, sum=0; the next op a=1, b=2 gives sum=3.
REQ-026 Parameter sweep: WIDTH=8, CHUNK=8 and WIDTH=32, CHUNK=4 -> 1000 random add/sub ops per configuration match the reference model {carry, a±b}, with latency NCHUNK+1.
